// File: rtl/max_stream_driver_pkg.sv
// Shared types for the find_MAX operand-stream initiator: FSM encoding,
// opcodes and the buffered operand-pair layout.
package max_stream_driver_pkg;

  localparam int DW = 8;
  localparam int IW = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ONE_LEFT = 3'd2,
    SEND     = 3'd3,
    WAIT_FIN = 3'd4
  } state_t;

  localparam logic [IW-1:0] OP_ADD     = 3'b000;
  localparam logic [IW-1:0] OP_SUB     = 3'b001;
  localparam logic [IW-1:0] OP_AND     = 3'b010;
  localparam logic [IW-1:0] OP_OR      = 3'b011;
  localparam logic [IW-1:0] OP_XOR     = 3'b100;
  localparam logic [IW-1:0] OP_SHL     = 3'b101;
  localparam logic [IW-1:0] OP_SHR     = 3'b110;
  localparam logic [IW-1:0] OP_ROL_ADD = 3'b111;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [IW-1:0] instr;
  } pair_t;

endpackage

// File: rtl/max_stream_driver_if.sv
// Operand stream toward find_MAX plus its finish/maximum return path.
interface max_stream_driver_if;
  import max_stream_driver_pkg::*;

  logic          start;
  logic          valid;
  logic          one_left;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic [IW-1:0] instruction;
  logic          finish_in;
  logic [DW-1:0] maximum_in;

  modport master (
    output start, valid, one_left, data_a, data_b, instruction,
    input  finish_in, maximum_in
  );

  modport slave (
    input  start, valid, one_left, data_a, data_b, instruction,
    output finish_in, maximum_in
  );

endinterface

// File: rtl/max_stream_driver_pair_buffer.sv
// Host-loaded operand-pair store; unreset registers, async read by index.
module max_stream_driver_pair_buffer
  import max_stream_driver_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pair_t         wdata,
  input  logic [AW-1:0] raddr,
  output pair_t         rdata
);

  pair_t mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/max_stream_driver.sv
// Replays N buffered operand pairs with start/one_left framing, then waits
// (bounded) for finish and captures the returned maximum.
module max_stream_driver
  import max_stream_driver_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [DW-1:0]  wr_data_a,
  input  logic [DW-1:0]  wr_data_b,
  input  logic [IW-1:0]  wr_instr,
  input  logic           go,
  input  logic [AW:0]    count,
  input  logic           stall,
  max_stream_driver_if.master bus,
  output logic           busy,
  output logic           done,
  output logic [DW-1:0]  result,
  output logic           timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [AW:0]   idx_q, idx_d, n_q, n_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  pair_t         pair_q, pair_d, rd_pair;
  logic          start_q, start_d, valid_q, valid_d, ol_q, ol_d;
  logic          busy_d, done_d, terr_d, launch;
  logic [DW-1:0] result_d;

  max_stream_driver_pair_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (wr_en && !busy),
    .waddr (wr_addr),
    .wdata ('{a: wr_data_a, b: wr_data_b, instr: wr_instr}),
    .raddr (idx_q[AW-1:0]),
    .rdata (rd_pair)
  );

  // Outputs are registered, so each transition computes what the next
  // cycle shows: a beat is launched on the edge that enters its cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    n_d      = n_q;
    tcnt_d   = tcnt_q;
    pair_d   = pair_q;
    start_d  = 1'b0;
    valid_d  = 1'b0;
    ol_d     = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;
    result_d = result;
    terr_d   = timeout_err;
    launch   = 1'b0;
    case (state_q)
      IDLE: if (go && count != '0) begin
        state_d = START;
        n_d     = (count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : count;
        idx_d   = '0;
        terr_d  = 1'b0;
        start_d = 1'b1;
        busy_d  = 1'b1;
      end
      START: if (n_q == (AW+1)'(1)) begin
        state_d = ONE_LEFT;
        ol_d    = 1'b1;
      end else begin
        state_d = SEND;
        launch  = 1'b1;
      end
      ONE_LEFT: begin
        state_d = SEND;
        launch  = 1'b1;
      end
      SEND: if (idx_q == n_q) begin
        state_d = WAIT_FIN;
        tcnt_d  = '0;
      end else begin
        launch  = 1'b1;
      end
      WAIT_FIN: if (bus.finish_in) begin
        state_d  = IDLE;
        result_d = bus.maximum_in;
        done_d   = 1'b1;
        busy_d   = 1'b0;
      end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
        state_d  = IDLE;
        result_d = '0;
        terr_d   = 1'b1;
        done_d   = 1'b1;
        busy_d   = 1'b0;
      end else begin
        tcnt_d   = tcnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A stalled launch is a bubble: index and data hold.
    if (launch && !stall) begin
      valid_d = 1'b1;
      pair_d  = rd_pair;
      ol_d    = ((AW+1)'(idx_q + (AW+1)'(2)) == n_q);
      idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      n_q         <= '0;
      tcnt_q      <= '0;
      pair_q      <= '0;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
      ol_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      tcnt_q      <= tcnt_d;
      pair_q      <= pair_d;
      start_q     <= start_d;
      valid_q     <= valid_d;
      ol_q        <= ol_d;
      busy        <= busy_d;
      done        <= done_d;
      result      <= result_d;
      timeout_err <= terr_d;
    end
  end

  assign bus.start       = start_q;
  assign bus.valid       = valid_q;
  assign bus.one_left    = ol_q;
  assign bus.data_a      = pair_q.a;
  assign bus.data_b      = pair_q.b;
  assign bus.instruction = pair_q.instr;

endmodule

// File: tb/tb_max_stream_driver.sv
// Randomized + directed bench for max_stream_driver with a sum-max receiver.
module tb_max_stream_driver;
  import max_stream_driver_pkg::*;

  localparam int DEPTH = 8, AW = 3, TIMEOUT = 16;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          wr_en = 1'b0, go = 1'b0, stall = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data_a = '0, wr_data_b = '0;
  logic [2:0]    wr_instr = '0;
  logic [AW:0]   count = '0;
  logic          busy, done, timeout_err;
  logic [7:0]    result;

  max_stream_driver_if bus();

  max_stream_driver #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .wr_instr(wr_instr),
    .go(go), .count(count), .stall(stall), .bus(bus),
    .busy(busy), .done(done), .result(result), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [7:0] ma [DEPTH];
  logic [7:0] mb [DEPTH];
  logic [2:0] mi [DEPTH];
  bit         stl [150];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wr(input int addr, input int a, input int b, input int i);
    wr_en = 1'b1; wr_addr = AW'(addr);
    wr_data_a = 8'(a); wr_data_b = 8'(b); wr_instr = 3'(i);
    @(negedge clk);
    wr_en = 1'b0;
    ma[addr] = 8'(a); mb[addr] = 8'(b); mi[addr] = 3'(i);
  endtask

  task automatic clr_stall();
    for (int c = 0; c < 150; c++) stl[c] = 1'b0;
  endtask

  // Cycle 0 is the cycle go is presented; every cycle is observed at negedge.
  task automatic run_op(input string nm, input int cnt, input bit rx_en, input bit poke);
    int n, first, t, k, exp_done, exp_res, fin_at;
    int starts, start_c, beats, ol_solo, ol_solo_c, dones, done_c;
    int res_d, err_d, err_c1, busy_bad, rx_max, s;
    int exp_vc[$];
    n = (cnt > DEPTH) ? DEPTH : cnt;
    first = (n == 1) ? 2 : 1;
    for (int c = 0; c <= first; c++) stl[c] = 1'b0;
    t = first; k = 0;
    while (k < n && t < 149) begin
      if (!stl[t]) begin exp_vc.push_back(t + 1); k++; end
      t++;
    end
    exp_res = 0;
    for (int j = 0; j < n; j++)
      if (((int'(ma[j]) + int'(mb[j])) & 255) > exp_res) exp_res = (int'(ma[j]) + int'(mb[j])) & 255;
    if (!rx_en) exp_res = 0;
    exp_done = exp_vc[$] + (rx_en ? 2 : 1 + TIMEOUT);
    starts = 0; start_c = -1; beats = 0; ol_solo = 0; ol_solo_c = -1; dones = 0;
    done_c = -1; res_d = -1; err_d = -1; err_c1 = -1; busy_bad = 0; rx_max = 0; fin_at = -1;
    go = 1'b1; count = (AW+1)'(cnt);
    for (int c = 1; c <= exp_done + 3 && c < 150; c++) begin
      @(negedge clk);
      if (c == 1) err_c1 = int'(timeout_err);
      if (bus.start) begin starts++; if (start_c < 0) start_c = c; end
      if (bus.valid) begin
        if (beats < n) begin
          chk({nm, " beat cycle"}, c, exp_vc[beats]);
          chk({nm, " beat data"}, int'({bus.data_a, bus.data_b, bus.instruction}),
              int'({ma[beats], mb[beats], mi[beats]}));
          chk({nm, " beat one_left"}, int'(bus.one_left), int'(beats == n - 2));
        end
        s = (int'(bus.data_a) + int'(bus.data_b)) & 255;
        if (s > rx_max) rx_max = s;
        beats++;
        if (beats == n) fin_at = c + 1;
      end else if (bus.one_left) begin
        ol_solo++; ol_solo_c = c;
      end
      if (done) begin dones++; done_c = c; res_d = int'(result); err_d = int'(timeout_err); end
      if (busy != (c < exp_done)) busy_bad++;
      go = poke && (c == 3);
      wr_en = poke && (c == 3); wr_addr = '0;
      wr_data_a = 8'hFF; wr_data_b = 8'hFF; wr_instr = 3'h7;
      stall = stl[c];
      bus.finish_in = rx_en && (fin_at == c);
      bus.maximum_in = 8'(rx_max);
    end
    go = 1'b0; wr_en = 1'b0; stall = 1'b0; bus.finish_in = 1'b0;
    chk({nm, " start count"}, starts, 1);
    chk({nm, " start cycle"}, start_c, 1);
    chk({nm, " beat count"}, beats, n);
    chk({nm, " solo one_left"}, ol_solo, int'(n == 1));
    if (n == 1) chk({nm, " solo one_left cycle"}, ol_solo_c, 2);
    chk({nm, " done count"}, dones, 1);
    chk({nm, " done cycle"}, done_c, exp_done);
    chk({nm, " result"}, res_d, exp_res);
    chk({nm, " timeout_err"}, err_d, int'(!rx_en));
    chk({nm, " err cleared on go"}, err_c1, 0);
    chk({nm, " busy window"}, busy_bad, 0);
  endtask

  initial begin
    int st, bz;
    bus.finish_in = 1'b0; bus.maximum_in = '0;
    clr_stall();
    repeat (2) @(negedge clk);
    chk("reset ctrl", int'({bus.start, bus.valid, bus.one_left, busy, done, timeout_err}), 0);
    chk("reset data", int'({bus.data_a, bus.data_b, bus.instruction, result}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    wr(0, 3, 4, 0); wr(1, 10, 1, 0); wr(2, 2, 2, 0);
    run_op("basic3", 3, 1'b1, 1'b0);
    chk("basic3 held result", int'(result), 11);

    wr(0, 200, 55, 0);
    run_op("single", 1, 1'b1, 1'b0);

    wr(0, 3, 4, 0);
    stl[3] = 1'b1; stl[4] = 1'b1;
    run_op("stall3", 3, 1'b1, 1'b0);
    clr_stall();

    run_op("timeout", 3, 1'b0, 1'b0);
    chk("timeout sticky", int'(timeout_err), 1);
    run_op("after_to", 3, 1'b1, 1'b0);

    run_op("poke", 3, 1'b1, 1'b1);
    run_op("rerun", 3, 1'b1, 1'b0);

    go = 1'b1; count = '0;
    st = 0; bz = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      go = 1'b0;
      if (bus.start) st++;
      if (busy) bz++;
    end
    chk("count0 start", st, 0);
    chk("count0 busy", bz, 0);

    for (int j = 0; j < DEPTH; j++) wr(j, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));
    go = 1'b1; count = 4'd8;
    repeat (4) @(negedge clk);
    go = 1'b0;
    chk("pre-reset valid", int'(bus.valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset ctrl", int'({bus.start, bus.valid, bus.one_left, busy, done}), 0);
    chk("mid reset data", int'({bus.data_a, bus.data_b, result}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_reset", 8, 1'b1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < DEPTH; j++)
        wr(j, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));
      clr_stall();
      for (int c = 0; c < 60; c++) stl[c] = ($urandom_range(0, 2) == 0);
      run_op($sformatf("rand%0d", r), $urandom_range(1, 15), $urandom_range(0, 4) != 0, r[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
